traffic_road_model: RTL
=======================

TRAFFIC_ROAD_MODEL -- requirements
Module: traffic_road_model

Interface
REQ-001 Parameter DEPART_GAP, default 4: number of consecutive local-road green cycles per departing car.
REQ-002 Parameter YEL_MAX, default 21: maximum legal consecutive cycles any light may show yellow.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 car_arrive  input  1  one car joins the local-road queue in each cycle this input is high.
REQ-006 hw_light  input  3  highway light from the controller: 100 green, 010 yellow, 001 red.
REQ-007 lr_light  input  3  local-road light, same encoding as hw_light.
REQ-008 lr_has_car  output  1  local-road queue is non-empty; drives the controller's car sensor.
REQ-009 car_count  output  4  local-road queue depth, 0..15.
REQ-010 cars_passed  output  8  total local-road departures, wraps 255->0.
REQ-011 drop  output  1  one-cycle pulse: an arrival was lost because the queue was full.
REQ-012 violation  output  1  sticky flag: a light-sequencing error was detected.
REQ-013 err_code  output  3  code of the first detected error; 0 means none.

Function
REQ-014 All outputs SHALL be registered or decoded only from registers; inputs sampled at edge N SHALL be reflected at edge N.
REQ-015 lr_has_car SHALL equal (car_count != 0).
REQ-016 gap_cnt SHALL count cycles with lr_light==100 and SHALL clear to 0 in any cycle with lr_light!=100.
REQ-017 A departure SHALL occur when lr_light==100, gap_cnt==DEPART_GAP-1 and car_count>0; gap_cnt SHALL then clear to 0.
REQ-018 When gap_cnt==DEPART_GAP-1 with car_count==0, gap_cnt SHALL clear to 0 and no departure SHALL occur.
REQ-019 On each departure, cars_passed SHALL increment by 1, modulo 256.
REQ-020 Arrival only: if car_count<15, car_count SHALL increment; if car_count==15, car_count SHALL hold and drop SHALL pulse high for 1 cycle.
REQ-021 Departure only: car_count SHALL decrement by 1.
REQ-022 Arrival and departure in the same cycle: car_count SHALL be unchanged and drop SHALL stay 0, including at depth 15.
REQ-023 The checker SHALL keep prev_hw and prev_lr registers holding the last sampled light values.
REQ-024 The checker SHALL keep per-light yellow-run counters that saturate at YEL_MAX+1.
REQ-025 Error code 1: hw_light or lr_light is not one of 100/010/001.
REQ-026 Error code 2: hw_light and lr_light are both non-red.
REQ-027 Error code 3: either light goes green directly to red (100->001).
REQ-028 Error code 4: either light goes red to yellow (001->010) or yellow to green (010->100).
REQ-029 Error code 5: either light is yellow for more than YEL_MAX consecutive cycles.
REQ-030 On the first error, violation SHALL be set and err_code loaded; both SHALL hold until reset, and later errors SHALL NOT alter err_code.
REQ-031 If several errors occur in the same first-error cycle, the lowest code SHALL win.
REQ-032 A cycle with an illegal encoding (code 1) SHALL NOT be evaluated for codes 3-5.
REQ-033 The queue logic SHALL keep operating after a violation.

Reset
REQ-034 While rst_n==0 at an edge, the block SHALL clear car_count, cars_passed, drop, violation, err_code, gap_cnt and both yellow counters to 0.
REQ-035 While rst_n==0 at an edge, the block SHALL set prev_hw=100 and prev_lr=001.
REQ-036 Checking SHALL begin at the first edge with rst_n==1.
REQ-037 Reset asserted mid-operation SHALL discard the queue and all error state within that edge.

Verification
REQ-038 Reset; hold hw=100, lr=001; 3 arrive pulses -> car_count=3, lr_has_car=1, violation=0.
REQ-039 car_count=2; lr=100 and hw=001 for 8 cycles -> departures at green cycles 4 and 8; car_count=0, cars_passed=2, lr_has_car=0.
REQ-040 car_count=15, car_arrive=1, lr red -> drop=1 for exactly one cycle, car_count stays 15.
REQ-041 car_count=5, arrival coincident with a departure -> car_count=5, cars_passed increments by 1.
REQ-042 hw goes 100->001 directly -> violation=1, err_code=3 next cycle; a later lr=110 leaves err_code at 3.
REQ-043 Yellow held 22 cycles -> err_code=5; hw=100 with lr=100 from clean reset -> err_code=2.

Source files
------------

// File: rtl/traffic_road_model.sv
// Local-road car queue fed by arrivals and drained on green, plus a checker
// that latches the first light-sequencing error seen on the two lights.
module traffic_road_model #(
    parameter int DEPART_GAP = 4,
    parameter int YEL_MAX    = 21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       car_arrive,
    input  logic [2:0] hw_light,
    input  logic [2:0] lr_light,
    output logic       lr_has_car,
    output logic [3:0] car_count,
    output logic [7:0] cars_passed,
    output logic       drop,
    output logic       violation,
    output logic [2:0] err_code
);

    localparam int GW = (DEPART_GAP > 1) ? $clog2(DEPART_GAP) : 1;
    localparam int YW = $clog2(YEL_MAX + 2);
    localparam logic [GW-1:0] GAP_LAST = GW'(DEPART_GAP - 1);
    localparam logic [YW-1:0] YEL_LIM  = YW'(YEL_MAX);
    localparam logic [YW-1:0] YEL_SAT  = YW'(YEL_MAX + 1);
    localparam logic [2:0] GREEN  = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b001;

    logic [3:0]    car_count_q, car_count_d;
    logic [7:0]    cars_passed_q, cars_passed_d;
    logic          drop_q, drop_d;
    logic          violation_q, violation_d;
    logic [2:0]    err_code_q, err_code_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [YW-1:0] hw_yel_q, hw_yel_d;
    logic [YW-1:0] lr_yel_q, lr_yel_d;
    logic [2:0]    prev_hw_q, prev_hw_d;
    logic [2:0]    prev_lr_q, prev_lr_d;

    logic lr_green, gap_done, depart;
    logic illegal, err2, err3, err4, err5;
    logic [2:0] first_code;

    // Queue: departures are spaced DEPART_GAP green cycles apart.
    always_comb begin
        lr_green      = (lr_light == GREEN);
        gap_done      = lr_green && (gap_q == GAP_LAST);
        depart        = gap_done && (car_count_q != 4'd0);
        gap_d         = (lr_green && !gap_done) ? gap_q + 1'b1 : '0;
        car_count_d   = car_count_q;
        cars_passed_d = depart ? cars_passed_q + 8'd1 : cars_passed_q;
        drop_d        = 1'b0;
        if (car_arrive && !depart) begin
            if (car_count_q == 4'd15) drop_d = 1'b1;
            else                      car_count_d = car_count_q + 4'd1;
        end else if (!car_arrive && depart) begin
            car_count_d = car_count_q - 4'd1;
        end
    end

    // Checker: codes 3-5 are only meaningful when both encodings are legal.
    always_comb begin
        prev_hw_d = hw_light;
        prev_lr_d = lr_light;
        hw_yel_d  = (hw_light != YELLOW) ? '0 :
                    (hw_yel_q == YEL_SAT) ? hw_yel_q : hw_yel_q + 1'b1;
        lr_yel_d  = (lr_light != YELLOW) ? '0 :
                    (lr_yel_q == YEL_SAT) ? lr_yel_q : lr_yel_q + 1'b1;
        illegal = !(hw_light == GREEN || hw_light == YELLOW || hw_light == RED) ||
                  !(lr_light == GREEN || lr_light == YELLOW || lr_light == RED);
        err2 = (hw_light != RED) && (lr_light != RED);
        err3 = !illegal && ((prev_hw_q == GREEN && hw_light == RED) ||
                            (prev_lr_q == GREEN && lr_light == RED));
        err4 = !illegal && ((prev_hw_q == RED    && hw_light == YELLOW) ||
                            (prev_hw_q == YELLOW && hw_light == GREEN)  ||
                            (prev_lr_q == RED    && lr_light == YELLOW) ||
                            (prev_lr_q == YELLOW && lr_light == GREEN));
        err5 = !illegal && ((hw_yel_d > YEL_LIM) || (lr_yel_d > YEL_LIM));
        first_code = illegal ? 3'd1 : err2 ? 3'd2 : err3 ? 3'd3 :
                     err4 ? 3'd4 : err5 ? 3'd5 : 3'd0;
        violation_d = violation_q || (first_code != 3'd0);
        err_code_d  = violation_q ? err_code_q : first_code;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            car_count_q   <= '0;
            cars_passed_q <= '0;
            drop_q        <= 1'b0;
            violation_q   <= 1'b0;
            err_code_q    <= '0;
            gap_q         <= '0;
            hw_yel_q      <= '0;
            lr_yel_q      <= '0;
            prev_hw_q     <= GREEN;
            prev_lr_q     <= RED;
        end else begin
            car_count_q   <= car_count_d;
            cars_passed_q <= cars_passed_d;
            drop_q        <= drop_d;
            violation_q   <= violation_d;
            err_code_q    <= err_code_d;
            gap_q         <= gap_d;
            hw_yel_q      <= hw_yel_d;
            lr_yel_q      <= lr_yel_d;
            prev_hw_q     <= prev_hw_d;
            prev_lr_q     <= prev_lr_d;
        end
    end

    assign lr_has_car  = (car_count_q != 4'd0);
    assign car_count   = car_count_q;
    assign cars_passed = cars_passed_q;
    assign drop        = drop_q;
    assign violation   = violation_q;
    assign err_code    = err_code_q;

endmodule
